// File: rtl/converge_pkg.sv
// Shared types and constants for the convergence iteration scheduler.
package converge_pkg;

   localparam int unsigned N_STOCKS = 2;
   localparam int unsigned WIDTH    = 16;
   localparam int unsigned FRAC     = 10;
   localparam int unsigned FIX_ONE  = 32'(1) << FRAC;

   typedef logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/converge_ctrl_if.sv
// Control, multiplier handshake and status bundle of converge_ctrl.
// The err signal exists only when CONV_TIMEOUT_EN is defined.
interface converge_ctrl_if #(
   parameter int unsigned MAX_ITER = 16
) ();
   localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

   logic                    start;
   converge_pkg::matrix_t   matrix_in;
   logic                    conv_in;
   logic                    mul_valid;
   logic                    mul_ready;
   converge_pkg::matrix_t   mul_a;
   logic                    mul_done;
   converge_pkg::matrix_t   mul_result;
   converge_pkg::matrix_t   matrix_out;
   logic                    busy;
   logic                    done;
   logic                    converged;
   logic [ITER_W-1:0]       iter_count;
`ifdef CONV_TIMEOUT_EN
   logic                    err;
`endif

   // Controller side
   modport master (
      input  start, matrix_in, conv_in, mul_ready, mul_done, mul_result,
      output mul_valid, mul_a, matrix_out, busy, done, converged, iter_count
`ifdef CONV_TIMEOUT_EN
      , output err
`endif
   );

   // Parent / multiplier side
   modport slave (
      output start, matrix_in, conv_in, mul_ready, mul_done, mul_result,
      input  mul_valid, mul_a, matrix_out, busy, done, converged, iter_count
`ifdef CONV_TIMEOUT_EN
      , input err
`endif
   );

endinterface

// File: rtl/converge_ctrl.sv
// Iteration scheduler: squares a latched matrix through an external
// multiplier until the sibling converge checker flags convergence or
// MAX_ITER multiplications are done. Optional WAIT watchdog under the
// CONV_TIMEOUT_EN macro.
module converge_ctrl
   import converge_pkg::*;
#(
   parameter int unsigned MAX_ITER = 16
`ifdef CONV_TIMEOUT_EN
   , parameter int unsigned TIMEOUT = 64
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   converge_ctrl_if.master       bus
);

   localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);
`ifdef CONV_TIMEOUT_EN
   localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
`endif

   state_t            r_state;
   matrix_t           r_mat;
   logic [ITER_W-1:0] r_iter;
   logic              r_conv;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
`ifdef CONV_TIMEOUT_EN
   logic [WD_W-1:0]   r_wdog;
   logic              r_err;
`endif

   // Operand and visible matrix are the same register, so it stays stable in ISSUE
   assign bus.mul_a      = r_mat;
   assign bus.matrix_out = r_mat;
   assign bus.mul_valid  = r_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.converged  = r_conv;
   assign bus.iter_count = r_iter;
`ifdef CONV_TIMEOUT_EN
   assign bus.err        = r_err;
`endif

   // FSM with registered outputs; iter_count cannot pass MAX_ITER since CHECK exits there
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mat   <= '0;
         r_iter  <= '0;
         r_conv  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef CONV_TIMEOUT_EN
         r_wdog  <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mat   <= bus.matrix_in;
                  r_iter  <= '0;
                  r_conv  <= 1'b0;
                  r_busy  <= 1'b1;
`ifdef CONV_TIMEOUT_EN
                  r_err   <= 1'b0;
`endif
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (bus.conv_in) begin
                  r_conv  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_iter == ITER_W'(MAX_ITER)) begin
                  r_conv  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_valid <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_valid && bus.mul_ready) begin
                  r_valid <= 1'b0;
`ifdef CONV_TIMEOUT_EN
                  r_wdog  <= '0;
`endif
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mul_done) begin
                  r_mat   <= bus.mul_result;
                  r_iter  <= r_iter + ITER_W'(1);
                  r_state <= S_CHECK;
               end
`ifdef CONV_TIMEOUT_EN
               else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_conv  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_wdog  <= r_wdog + WD_W'(1);
               end
`endif
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_converge_ctrl.sv
// Directed bench for converge_ctrl; the timeout step is built only with CONV_TIMEOUT_EN.
module tb_converge_ctrl;
   import converge_pkg::*;

   localparam int unsigned MAX_ITER = 4;
   localparam int unsigned TIMEOUT  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   hs_cnt = 0;
   int   done_cnt = 0;
   int   valid_cyc = 0;

   always #5 clk = ~clk;

   converge_ctrl_if #(.MAX_ITER(MAX_ITER)) bus ();

   converge_ctrl #(
      .MAX_ITER(MAX_ITER)
`ifdef CONV_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Event counters for handshakes, done pulses and mul_valid cycles
   always @(posedge clk) begin
      if (!rst && bus.mul_valid && bus.mul_ready) hs_cnt <= hs_cnt + 1;
      if (!rst && bus.done) done_cnt <= done_cnt + 1;
      if (!rst && bus.mul_valid) valid_cyc <= valid_cyc + 1;
   end

   function automatic matrix_t mk(input int a, input int b, input int c, input int d);
      matrix_t m;
      m[0][0] = WIDTH'(a);
      m[0][1] = WIDTH'(b);
      m[1][0] = WIDTH'(c);
      m[1][1] = WIDTH'(d);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (bus.mul_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("wait_valid", 64'(bus.mul_valid), 64'(1));
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("wait_done", 64'(bus.done), 64'(1));
   endtask

   // Accept one request (mul_ready assumed 1) and return res 3 cycles later
   task automatic do_mul(input matrix_t res);
      wait_valid();
      tick();
      tick();
      tick();
      bus.mul_done   = 1'b1;
      bus.mul_result = res;
      tick();
      bus.mul_done   = 1'b0;
   endtask

   initial begin
      matrix_t m_one, m_id, m_r, m_b, m_c;
      int hs0, dn0, vc0;
      m_one = mk(1024, 1024, 1024, 1024);
      m_id  = mk(1024, 0, 0, 1024);
      m_r   = mk(512, -256, 300, -1024);
      m_b   = mk(-1, 2, -3, 4);
      m_c   = mk(7, 7, 7, 7);

      bus.start = 1'b0; bus.matrix_in = '0; bus.conv_in = 1'b0;
      bus.mul_ready = 1'b0; bus.mul_done = 1'b0; bus.mul_result = '0;

      // Reset
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_valid", 64'(bus.mul_valid), 64'(0));
      chk("rst_mat", 64'(bus.matrix_out), 64'(0));
      chk("rst_iter", 64'(bus.iter_count), 64'(0));
      chk("rst_conv", 64'(bus.converged), 64'(0));
`ifdef CONV_TIMEOUT_EN
      chk("rst_err", 64'(bus.err), 64'(0));
`endif

      // Already converged: done in cycle k+2, no multiplication
      hs0 = hs_cnt; vc0 = valid_cyc;
      bus.conv_in = 1'b1; bus.matrix_in = m_one; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t1_busy", 64'(bus.busy), 64'(1));
      chk("t1_done_early", 64'(bus.done), 64'(0));
      tick();
      chk("t1_done", 64'(bus.done), 64'(1));
      chk("t1_conv", 64'(bus.converged), 64'(1));
      chk("t1_iter", 64'(bus.iter_count), 64'(0));
      chk("t1_mat", 64'(bus.matrix_out), 64'(m_one));
      tick();
      chk("t1_done_pulse", 64'(bus.done), 64'(0));
      chk("t1_idle", 64'(bus.busy), 64'(0));
      chk("t1_no_valid", 64'(valid_cyc - vc0), 64'(0));
      chk("t1_no_hs", 64'(hs_cnt - hs0), 64'(0));

      // Converges after the second writeback
      hs0 = hs_cnt; dn0 = done_cnt;
      bus.conv_in = 1'b0; bus.mul_ready = 1'b1; bus.matrix_in = m_id; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_valid();
      chk("t2_mul_a", 64'(bus.mul_a), 64'(m_id));
      do_mul(m_id);
      chk("t2_iter1", 64'(bus.iter_count), 64'(1));
      do_mul(m_r);
      bus.conv_in = 1'b1;
      wait_done();
      chk("t2_conv", 64'(bus.converged), 64'(1));
      chk("t2_iter", 64'(bus.iter_count), 64'(2));
      chk("t2_mat", 64'(bus.matrix_out), 64'(m_r));
      tick();
      bus.conv_in = 1'b0;
      tick();
      chk("t2_hs", 64'(hs_cnt - hs0), 64'(2));
      chk("t2_done_cnt", 64'(done_cnt - dn0), 64'(1));
      chk("t2_hold_iter", 64'(bus.iter_count), 64'(2));

      // Never converges: stops after MAX_ITER handshakes
      hs0 = hs_cnt;
      bus.matrix_in = m_b; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < int'(MAX_ITER); i++) do_mul(m_b);
      wait_done();
      chk("t3_conv", 64'(bus.converged), 64'(0));
      chk("t3_iter", 64'(bus.iter_count), 64'(MAX_ITER));
      tick(); tick(); tick();
      chk("t3_hs", 64'(hs_cnt - hs0), 64'(MAX_ITER));
      chk("t3_no_valid", 64'(bus.mul_valid), 64'(0));

      // Backpressure, start while busy, reset in WAIT with a late mul_done
      hs0 = hs_cnt;
      bus.mul_ready = 1'b0; bus.matrix_in = m_b; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_valid_held", 64'(bus.mul_valid), 64'(1));
         chk("t4_mul_a", 64'(bus.mul_a), 64'(m_b));
         chk("t4_no_hs", 64'(hs_cnt - hs0), 64'(0));
         tick();
      end
      bus.mul_ready = 1'b1;
      tick();
      chk("t4_wait_valid", 64'(bus.mul_valid), 64'(0));
      chk("t4_hs", 64'(hs_cnt - hs0), 64'(1));
      bus.matrix_in = m_c; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t4_busy_start_mat", 64'(bus.matrix_out), 64'(m_b));
      chk("t4_busy_start_iter", 64'(bus.iter_count), 64'(0));
      chk("t4_still_busy", 64'(bus.busy), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rst_mat", 64'(bus.matrix_out), 64'(0));
      chk("t4_rst_busy", 64'(bus.busy), 64'(0));
      chk("t4_rst_valid", 64'(bus.mul_valid), 64'(0));
      tick();
      bus.mul_done = 1'b1; bus.mul_result = m_c;
      tick();
      bus.mul_done = 1'b0;
      chk("t4_late_mat", 64'(bus.matrix_out), 64'(0));
      chk("t4_late_iter", 64'(bus.iter_count), 64'(0));
      chk("t4_late_busy", 64'(bus.busy), 64'(0));
      chk("t4_late_done", 64'(bus.done), 64'(0));

`ifdef CONV_TIMEOUT_EN
      // Watchdog: done 8 cycles after WAIT entry, err cleared by next start
      begin
         int n = 0;
         bus.mul_ready = 1'b1; bus.conv_in = 1'b0; bus.matrix_in = m_id; bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         wait_valid();
         tick();
         while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         chk("t5_latency", 64'(n), 64'(TIMEOUT));
         chk("t5_err", 64'(bus.err), 64'(1));
         chk("t5_conv", 64'(bus.converged), 64'(0));
         tick();
         bus.conv_in = 1'b1; bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         chk("t5_err_clr", 64'(bus.err), 64'(0));
         wait_done();
         tick();
         bus.conv_in = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/converge_ctrl.md
Name: converge_ctrl

Overview:
Iteration scheduler for the convergence path.
- Latches an N_STOCKS x N_STOCKS signed fixed-point matrix.
- Repeatedly hands it to the external matrix-multiply unit (squaring) over a valid/ready + done handshake.
- Writes each product back and samples the flag from the `converge` checker, which the parent instantiates on `matrix_out`.
- Stops on convergence or after MAX_ITER multiplications, then reports the result and the iteration count.

Parameters:
N_STOCKS, 2, matrix dimension
WIDTH, 16, bits per signed entry
FRAC, 10, fractional bits (1.0 = 16'd1024)
MAX_ITER, 16, maximum multiplications per run (>=1)
TIMEOUT, 64, cycles allowed in WAIT (only with CONV_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
matrix_in  in  N_STOCKS*N_STOCKS*WIDTH  initial matrix, signed [N][N][WIDTH] packed
conv_in  in  1  combinational flag from the `converge` instance driven by matrix_out
mul_valid  out  1  multiply request
mul_ready  in  1  multiplier accepts request
mul_a  out  N_STOCKS*N_STOCKS*WIDTH  operand (equals matrix_out)
mul_done  in  1  one-cycle pulse, mul_result valid
mul_result  in  N_STOCKS*N_STOCKS*WIDTH  product matrix
matrix_out  out  N_STOCKS*N_STOCKS*WIDTH  current matrix register
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
converged  out  1  run ended by conv_in
iter_count  out  $clog2(MAX_ITER+1)  multiplications completed
err  out  1  timeout flag (port present only with CONV_TIMEOUT_EN)

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; all outputs 0 (matrix_out=0, iter_count=0, mul_valid=0). Reset overrides all other inputs in the same cycle.
- FSM states: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE:
  - start=1: mat_reg<=matrix_in; iter_count<=0; converged<=0; ->CHECK.
  - start in any other state is ignored.
- CHECK (one cycle, samples conv_in against the current mat_reg):
  - conv_in=1: converged<=1, ->DONE.
  - else if iter_count==MAX_ITER: converged<=0, ->DONE.
  - else ->ISSUE.
- ISSUE: mul_valid=1; mul_a and matrix_out held stable; on mul_valid&&mul_ready ->WAIT. Backpressure of any length is allowed.
- WAIT: mul_valid=0; on mul_done: mat_reg<=mul_result, iter_count<=iter_count+1, ->CHECK.
- DONE: done=1 for exactly one cycle, ->IDLE.
- converged, iter_count and matrix_out hold until the next accepted start.
- mul_done outside WAIT is ignored.
- Minimum latency: start at edge k -> CHECK cycle k+1 -> done high in cycle k+2 (already-converged input, zero multiplications).
- Each iteration costs 1 ISSUE cycle (if ready) + multiplier latency + 1 CHECK cycle.
- iter_count saturates structurally at MAX_ITER and never wraps.
- Arithmetic: none internally. Matrices are passed through unchanged and are never rounded or saturated by this block.
- Reset mid-operation (e.g. in WAIT): return to IDLE. A subsequent late mul_done is ignored.

Optional Feature:
CONV_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in WAIT.
  - Reaching TIMEOUT without mul_done: err<=1, converged<=0, ->DONE.
  - err clears on the next accepted start or on reset.
- Undefined: no counter and no err port; WAIT lasts indefinitely.

Decomposition:
- Shared package converge_pkg:
  - state enum typedef
  - matrix typedef logic signed [N][N][WIDTH]
  - localparam FIX_ONE = 1<<FRAC
  - default N_STOCKS and WIDTH
- No sub-module: the FSM, mat_reg and the watchdog fit in one module.
- converge remains a sibling instantiated by the parent.

Test Plan:
- Matrix {1024,1024;1024,1024} with conv_in tied 1, start pulse -> done 2 cycles after start; converged=1; iter_count=0; mul_valid never asserted.
- Multiplier model: mul_ready=1, 3-cycle latency, result = input; conv_in rises after the 2nd writeback -> exactly 2 handshakes; iter_count=2; converged=1; one done pulse.
- conv_in held 0, MAX_ITER=4 -> 4 handshakes; done with converged=0, iter_count=4; no 5th mul_valid.
- mul_ready held 0 for 5 cycles in ISSUE -> mul_valid stays 1 and mul_a stable all 5 cycles; WAIT entered only on the ready cycle.
- rst pulsed in WAIT, then mul_done 2 cycles later -> all outputs 0, state IDLE, matrix_out unchanged by the late pulse. A start asserted while busy has no effect.
- With CONV_TIMEOUT_EN, TIMEOUT=8, mul_done never sent -> err=1 and done pulse 8 cycles after WAIT entry; next start clears err.
